// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each accepted request takes IDLE -> EXEC -> RESP; the result is held until the consumer takes it.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_ex,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_zero,
  output logic             rsp_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       r_state;
  logic             r_rr_ptr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_id;
  logic             r_err_l;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_z;
  logic             r_rsp_zero;
  logic             r_rsp_err;

  logic             w_idle;
  logic             w_exec;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_accept;
  logic [2:0]       w_in_op;
  logic             w_in_illegal;

  assign w_idle = (r_state == IDLE);
  assign w_exec = (r_state == EXEC);

  // A lone requester always wins; rr_ptr only breaks ties.
  assign w_gnt1   = req1_valid && (!req0_valid || r_rr_ptr);
  assign w_gnt0   = req0_valid && !w_gnt1;
  assign w_accept = w_idle && (req0_valid || req1_valid);

  assign req0_ready = w_idle && w_gnt0;
  assign req1_ready = w_idle && w_gnt1;

  assign w_in_op      = w_gnt1 ? req1_op : req0_op;
  assign w_in_illegal = !((w_in_op == 3'b000) || (w_in_op == 3'b001) ||
                          (w_in_op == 3'b010) || (w_in_op == 3'b110));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= 3'b000;
      r_id       <= 1'b0;
      r_err_l    <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_z    <= '0;
      r_rsp_zero <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= w_gnt1 ? req1_a : req0_a;
            r_b     <= w_gnt1 ? req1_b : req0_b;
            r_op    <= w_in_op;
            r_id    <= w_gnt1;
            r_err_l <= w_in_illegal;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_id <= r_id;
          if (r_err_l) begin
            r_rsp_z    <= '0;
            r_rsp_zero <= 1'b0;
            r_rsp_err  <= 1'b1;
          end else begin
            r_rsp_z    <= alu_z;
            r_rsp_zero <= alu_ex;
            r_rsp_err  <= 1'b0;
          end
          r_state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rr_ptr <= ~r_rsp_id;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // ALU sees operands only during EXEC; illegal ops present a harmless AND.
  assign alu_a  = w_exec ? r_a : '0;
  assign alu_b  = w_exec ? r_b : '0;
  assign alu_op = (w_exec && !r_err_l) ? r_op : 3'b000;

  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_z     = r_rsp_z;
  assign rsp_zero  = r_rsp_zero;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU, table-driven single requests, scoreboard on
// every response, and hand sequences for contention, fairness, backpressure and mid-op reset.
module tb_alu_share_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] alu_a, alu_b, alu_z;
  logic [2:0]   alu_op;
  logic         alu_ex;
  logic         rsp_valid, rsp_id, rsp_zero, rsp_err;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_z;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_z(alu_z), .alu_ex(alu_ex),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // External ALU the block is meant to drive.
  always_comb begin
    case (alu_op)
      3'b000:  alu_z = alu_a & alu_b;
      3'b001:  alu_z = alu_a | alu_b;
      3'b010:  alu_z = alu_a + alu_b;
      3'b110:  alu_z = alu_a - alu_b;
      default: alu_z = '0;
    endcase
  end
  assign alu_ex = (alu_z == '0);

  typedef struct {
    logic         id;
    logic [W-1:0] z;
    logic         zero;
    logic         err;
    int           cyc;
  } exp_t;

  typedef struct {
    logic         port;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] z;
    logic         zero;
    logic         err;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  exp_t         sb[$];
  logic         ret_id[$];
  logic [W-1:0] ret_z[$];
  int           ret_cyc[$];

  int           total = 0, bad = 0, cyc = 0;
  int           hs_cnt0 = 0, hs_cnt1 = 0;
  logic         hs0, hs1, prev_valid = 1'b0, hold_valid = 1'b0;
  logic         last_id, last_zero, last_err;
  logic [W-1:0] last_z;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t ref_rsp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] op, input int c);
    exp_t e;
    e.id = id; e.cyc = c; e.err = 1'b0;
    case (op)
      3'b000:  e.z = a & b;
      3'b001:  e.z = a | b;
      3'b010:  e.z = a + b;
      3'b110:  e.z = a - b;
      default: begin e.z = '0; e.err = 1'b1; end
    endcase
    e.zero = !e.err && (e.z == '0);
    return e;
  endfunction

  // One cycle: sample just before the rising edge, score, then advance to the next falling edge.
  task automatic tick();
    exp_t e;
    #1;
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    if (hs0) begin hs_cnt0++; sb.push_back(ref_rsp(1'b0, req0_a, req0_b, req0_op, cyc)); end
    if (hs1) begin hs_cnt1++; sb.push_back(ref_rsp(1'b1, req1_a, req1_b, req1_op, cyc)); end
    if (rsp_valid && !prev_valid) begin
      if (sb.size() == 0) chk("latency_no_request", 1, 0);
      else chk("latency", cyc - sb[0].cyc, 2);
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_z", rsp_z, e.z);
        chk("rsp_zero", rsp_zero, e.zero);
        chk("rsp_err", rsp_err, e.err);
      end
      last_id = rsp_id; last_z = rsp_z; last_zero = rsp_zero; last_err = rsp_err;
      ret_id.push_back(rsp_id); ret_z.push_back(rsp_z); ret_cyc.push_back(cyc);
    end
    prev_valid = rsp_valid;
    cyc++;
    @(negedge clk);
    if (!hold_valid) begin
      if (hs0) req0_valid = 1'b0;
      if (hs1) req1_valid = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((req0_valid || req1_valid || sb.size() != 0 || rsp_valid) && k < budget) begin
      tick();
      k++;
    end
    chk("drain_done", {31'd0, req0_valid || req1_valid || sb.size() != 0 || rsp_valid}, 0);
  endtask

  task automatic wait_first_hs(input string name, input logic exp_port);
    int k = 0;
    logic got = 1'b0;
    logic port = 1'b0;
    while (!got && k < 20) begin
      tick();
      if (hs0 || hs1) begin got = 1'b1; port = hs1; end
      k++;
    end
    chk({name, "_hs_seen"}, got, 1);
    chk({name, "_hs_port"}, port, exp_port);
  endtask

  task automatic apply_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0; hold_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_z", rsp_z, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    sb.delete();
    prev_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int h0, h1, seen;
    vecs[0] = '{1'b0, 32'd7,        32'd5,        3'b010, 32'd12,       1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'hF0,       32'h3C,       3'b000, 32'h30,       1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'hF0,       32'h3C,       3'b001, 32'hFC,       1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h10,       32'h3,        3'b110, 32'hD,        1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h1234,     32'h1234,     3'b110, 32'h0,        1'b1, 1'b0};
    vecs[5] = '{1'b1, 32'hA,        32'h5,        3'b011, 32'h0,        1'b0, 1'b1};
    vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'h1,        3'b010, 32'h0,        1'b1, 1'b0};
    vecs[7] = '{1'b1, 32'h5,        32'h7,        3'b110, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 32'hFF00,     32'hF0,       3'b000, 32'h0,        1'b1, 1'b0};
    vecs[9] = '{1'b0, 32'h0,        32'h0,        3'b011, 32'h0,        1'b0, 1'b1};

    @(negedge clk);
    apply_reset();

    // Single requests from the table.
    rsp_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      h0 = hs_cnt0; h1 = hs_cnt1;
      if (vecs[i].port) begin
        req1_a = vecs[i].a; req1_b = vecs[i].b; req1_op = vecs[i].op; req1_valid = 1'b1;
      end else begin
        req0_a = vecs[i].a; req0_b = vecs[i].b; req0_op = vecs[i].op; req0_valid = 1'b1;
      end
      drain(30);
      chk($sformatf("vec%0d_hs_count", i), vecs[i].port ? hs_cnt1 - h1 : hs_cnt0 - h0, 1);
      chk($sformatf("vec%0d_id", i), last_id, vecs[i].port);
      chk($sformatf("vec%0d_z", i), last_z, vecs[i].z);
      chk($sformatf("vec%0d_zero", i), last_zero, vecs[i].zero);
      chk($sformatf("vec%0d_err", i), last_err, vecs[i].err);
    end

    // Contention right after reset: req0 first, then req1, then pointer back at 0.
    apply_reset();
    rsp_ready = 1'b1;
    ret_id.delete(); ret_z.delete(); ret_cyc.delete();
    req0_a = 32'hF0; req0_b = 32'h3C; req0_op = 3'b000; req0_valid = 1'b1;
    req1_a = 32'hF0; req1_b = 32'h3C; req1_op = 3'b001; req1_valid = 1'b1;
    drain(40);
    chk("cont_count", ret_id.size(), 2);
    if (ret_id.size() == 2) begin
      chk("cont_id0", ret_id[0], 0);
      chk("cont_z0", ret_z[0], 32'h30);
      chk("cont_id1", ret_id[1], 1);
      chk("cont_z1", ret_z[1], 32'hFC);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_first_hs("cont_rr", 1'b0);
    drain(40);

    // Fairness: both held valid for 12 cycles.
    apply_reset();
    rsp_ready = 1'b1;
    ret_id.delete(); ret_z.delete(); ret_cyc.delete();
    hold_valid = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (12) tick();
    req0_valid = 1'b0; req1_valid = 1'b0; hold_valid = 1'b0;
    drain(20);
    chk("fair_count", ret_id.size(), 4);
    if (ret_id.size() == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("fair_id%0d", i), ret_id[i], i % 2);
      for (int i = 1; i < 4; i++)
        chk($sformatf("fair_gap%0d", i), ret_cyc[i] - ret_cyc[i-1], 3);
    end

    // Backpressure with zero flag; req0 must wait while the response is held.
    rsp_ready = 1'b0;
    req1_a = 32'h1234; req1_b = 32'h1234; req1_op = 3'b110; req1_valid = 1'b1;
    wait_first_hs("bp", 1'b1);
    req0_a = 32'd3; req0_b = 32'd4; req0_op = 3'b010; req0_valid = 1'b1;
    for (int k = 0; k < 10 && !rsp_valid; k++) tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("bp_valid%0d", k), rsp_valid, 1);
      chk($sformatf("bp_z%0d", k), rsp_z, 0);
      chk($sformatf("bp_zero%0d", k), rsp_zero, 1);
      chk($sformatf("bp_id%0d", k), rsp_id, 1);
      chk($sformatf("bp_req0_ready%0d", k), req0_ready, 0);
      chk($sformatf("bp_alu_a%0d", k), alu_a, 0);
      tick();
    end
    rsp_ready = 1'b1;
    drain(30);
    chk("bp_req0_served", last_z, 32'd7);

    // Reset during EXEC: pointer left at 1 beforehand, must come back as 0.
    req0_a = 32'd2; req0_b = 32'd3; req0_op = 3'b010; req0_valid = 1'b1;
    drain(30);
    req1_a = 32'd9; req1_b = 32'd9; req1_op = 3'b010; req1_valid = 1'b1;
    wait_first_hs("mid", 1'b1);
    #1;
    chk("mid_exec_alu_a", alu_a, 32'd9);
    apply_reset();
    rsp_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      #1;
      if (rsp_valid) seen++;
      tick();
    end
    chk("mid_no_rsp", seen, 0);
    req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b001; req0_valid = 1'b1;
    req1_a = 32'd4; req1_b = 32'd4; req1_op = 3'b000; req1_valid = 1'b1;
    wait_first_hs("mid_rr", 1'b0);
    drain(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
